tv80_regbank: RTL and testbench



---
 rtl/tv80_regbank_pkg.sv | 22 ++
 rtl/tv80_regbank_if.sv | 34 +++
 rtl/tv80_regbank_clr.sv | 65 ++++++
 rtl/tv80_regbank.sv | 118 +++++++++++
 tb/tb_tv80_regbank.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tv80_regbank_pkg.sv
// Shared types and helpers for the parametrised TV80 register bank.
// Holds the clear-sequencer state encoding, the default swap mask and clog2.
package tv80_regbank_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

  // Rows 0-2 (BC, DE, HL) have an alternate copy by default.
  localparam logic [7:0] DEF_SWAP_MASK = 8'b0000_0111;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      r = ((32'd1 << i) < n) ? (i + 32'd1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/tv80_regbank_if.sv
// Register-bank access bus: write/read addresses, write data and enables,
// exchange strobe, and the read data / status returned by the bank.
interface tv80_regbank_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          cen;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] dih;
  logic [DW-1:0] dil;
  logic          weh;
  logic          wel;
  logic          exx;
  logic [DW-1:0] doah;
  logic [DW-1:0] doal;
  logic [DW-1:0] dobh;
  logic [DW-1:0] dobl;
  logic [DW-1:0] doch;
  logic [DW-1:0] docl;
  logic          bank;
  logic          busy;

  modport master (
    output cen, addr_a, addr_b, addr_c, dih, dil, weh, wel, exx,
    input  doah, doal, dobh, dobl, doch, docl, bank, busy
  );

  modport slave (
    input  cen, addr_a, addr_b, addr_c, dih, dil, weh, wel, exx,
    output doah, doal, dobh, dobl, doch, docl, bank, busy
  );
endinterface

// File: rtl/tv80_regbank_clr.sv
// Post-reset clear sequencer: walks every row once, strobing it for zeroing,
// and holds the bank busy until the last row has been cleared.
module tv80_regbank_clr
  import tv80_regbank_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          busy,
  output logic          clr_stb,
  output logic [AW-1:0] clr_row
);

  localparam logic [AW-1:0] LAST_ROW = AW'(NREG - 1);

  clr_state_e    state_q;
  clr_state_e    state_d;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // State and row pointer; reset restarts the sweep from row 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      ptr_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: advance one row per edge, leave CLEAR after the last row.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ROW) begin
          state_d = RUN;
        end else begin
          state_d = CLEAR;
        end
      end
      RUN: begin
        state_d = RUN;
        ptr_d   = ptr_q;
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = {AW{1'b0}};
      end
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    busy    = (state_q == CLEAR);
    clr_stb = (state_q == CLEAR);
    clr_row = ptr_q;
  end

endmodule

// File: rtl/tv80_regbank.sv
// Dual-lane (H/L) register file with three read ports, one write port,
// a Z80-style alternate bank for masked rows, optional write bypass and
// a hardware clear after reset.
module tv80_regbank
  import tv80_regbank_pkg::*;
#(
  parameter int              DW        = 8,
  parameter int              NREG      = 8,
  parameter logic [NREG-1:0] SWAP_MASK = NREG'(DEF_SWAP_MASK),
  parameter bit              BYPASS    = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  tv80_regbank_if.slave  bus
);

  localparam int AW = clog2(NREG);

  logic                            busy;
  logic                            clr_stb;
  logic [AW-1:0]                   clr_row;
  logic                            bank_q;
  logic                            bank_d;
  logic [1:0][NREG-1:0][DW-1:0]    regh_q;
  logic [1:0][NREG-1:0][DW-1:0]    regh_d;
  logic [1:0][NREG-1:0][DW-1:0]    regl_q;
  logic [1:0][NREG-1:0][DW-1:0]    regl_d;
  logic                            wr_ok;
  logic                            wr_bank;
  logic [2:0][AW-1:0]              rd_addr;
  logic [2:0]                      rd_pb;
  logic [2:0]                      rd_hit;
  logic [2:0][DW-1:0]              rd_h;
  logic [2:0][DW-1:0]              rd_l;

  tv80_regbank_clr #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clr (
    .clk     (clk),
    .reset_n (reset_n),
    .busy    (busy),
    .clr_stb (clr_stb),
    .clr_row (clr_row)
  );

  // A write uses the bank as it was before any same-cycle exchange.
  always_comb begin
    wr_ok   = bus.cen & ~busy;
    wr_bank = SWAP_MASK[bus.addr_a] ? bank_q : 1'b0;
    bank_d  = (wr_ok && bus.exx) ? ~bank_q : bank_q;
    regh_d  = regh_q;
    regl_d  = regl_q;
    if (clr_stb) begin
      regh_d[1'b0][clr_row] = {DW{1'b0}};
      regh_d[1'b1][clr_row] = {DW{1'b0}};
      regl_d[1'b0][clr_row] = {DW{1'b0}};
      regl_d[1'b1][clr_row] = {DW{1'b0}};
    end else begin
      if (wr_ok && bus.weh) begin
        regh_d[wr_bank][bus.addr_a] = bus.dih;
      end else begin
        regh_d[wr_bank][bus.addr_a] = regh_q[wr_bank][bus.addr_a];
      end
      if (wr_ok && bus.wel) begin
        regl_d[wr_bank][bus.addr_a] = bus.dil;
      end else begin
        regl_d[wr_bank][bus.addr_a] = regl_q[wr_bank][bus.addr_a];
      end
    end
  end

  // Storage is cleared by the sequencer, so the arrays need no reset.
  always_ff @(posedge clk) begin
    regh_q <= regh_d;
    regl_q <= regl_d;
  end

  // Active bank for swappable rows.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bank_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign rd_addr = {bus.addr_c, bus.addr_b, bus.addr_a};

  // Read ports: same row as a qualified write may forward the enabled lanes.
  always_comb begin
    rd_pb  = 3'b000;
    rd_hit = 3'b000;
    rd_h   = {(3 * DW){1'b0}};
    rd_l   = {(3 * DW){1'b0}};
    for (int p = 0; p < 3; p++) begin
      rd_pb[p]  = SWAP_MASK[rd_addr[p]] ? bank_q : 1'b0;
      rd_hit[p] = (BYPASS == 1'b1) && wr_ok && (rd_addr[p] == bus.addr_a);
      if (busy) begin
        rd_h[p] = {DW{1'b0}};
        rd_l[p] = {DW{1'b0}};
      end else begin
        rd_h[p] = (rd_hit[p] && bus.weh) ? bus.dih : regh_q[rd_pb[p]][rd_addr[p]];
        rd_l[p] = (rd_hit[p] && bus.wel) ? bus.dil : regl_q[rd_pb[p]][rd_addr[p]];
      end
    end
  end

  assign bus.doah = rd_h[0];
  assign bus.doal = rd_l[0];
  assign bus.dobh = rd_h[1];
  assign bus.dobl = rd_l[1];
  assign bus.doch = rd_h[2];
  assign bus.docl = rd_l[2];
  assign bus.bank = bank_q;
  assign bus.busy = busy;

endmodule

// File: tb/tb_tv80_regbank.sv
// Bench for tv80_regbank: one instance without and one with bypass, driven
// identically and compared every cycle against a behavioural model.
module tb_tv80_regbank;

  localparam int DW   = 8;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam logic [7:0] SWAP = 8'b0000_0111;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  tv80_regbank_if #(.DW(DW), .AW(AW)) bus0 ();
  tv80_regbank_if #(.DW(DW), .AW(AW)) bus1 ();

  assign bus1.cen    = bus0.cen;
  assign bus1.addr_a = bus0.addr_a;
  assign bus1.addr_b = bus0.addr_b;
  assign bus1.addr_c = bus0.addr_c;
  assign bus1.dih    = bus0.dih;
  assign bus1.dil    = bus0.dil;
  assign bus1.weh    = bus0.weh;
  assign bus1.wel    = bus0.wel;
  assign bus1.exx    = bus0.exx;

  tv80_regbank #(.DW(DW), .NREG(NREG), .SWAP_MASK(SWAP), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  tv80_regbank #(.DW(DW), .NREG(NREG), .SWAP_MASK(SWAP), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: contents per bank, active bank, edges left in the clear.
  int mh [2][NREG];
  int ml [2][NREG];
  int mbank;
  int clr_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int pbank(input int a);
    return SWAP[a] ? mbank : 0;
  endfunction

  function automatic int exp_rd(input int a, input bit hi, input bit byp);
    bit fwd;
    if (clr_left > 0) return 0;
    fwd = byp && bus0.cen && (a == int'(bus0.addr_a));
    if (hi) return (fwd && bus0.weh) ? int'(bus0.dih) : mh[pbank(a)][a];
    return (fwd && bus0.wel) ? int'(bus0.dil) : ml[pbank(a)][a];
  endfunction

  task automatic check_all();
    chk("d0_busy", bus0.busy, (clr_left > 0));
    chk("d1_busy", bus1.busy, (clr_left > 0));
    chk("d0_bank", bus0.bank, mbank);
    chk("d1_bank", bus1.bank, mbank);
    chk("d0_doah", bus0.doah, exp_rd(bus0.addr_a, 1'b1, 1'b0));
    chk("d0_doal", bus0.doal, exp_rd(bus0.addr_a, 1'b0, 1'b0));
    chk("d0_dobh", bus0.dobh, exp_rd(bus0.addr_b, 1'b1, 1'b0));
    chk("d0_dobl", bus0.dobl, exp_rd(bus0.addr_b, 1'b0, 1'b0));
    chk("d0_doch", bus0.doch, exp_rd(bus0.addr_c, 1'b1, 1'b0));
    chk("d0_docl", bus0.docl, exp_rd(bus0.addr_c, 1'b0, 1'b0));
    chk("d1_doah", bus1.doah, exp_rd(bus0.addr_a, 1'b1, 1'b1));
    chk("d1_doal", bus1.doal, exp_rd(bus0.addr_a, 1'b0, 1'b1));
    chk("d1_dobh", bus1.dobh, exp_rd(bus0.addr_b, 1'b1, 1'b1));
    chk("d1_dobl", bus1.dobl, exp_rd(bus0.addr_b, 1'b0, 1'b1));
    chk("d1_doch", bus1.doch, exp_rd(bus0.addr_c, 1'b1, 1'b1));
    chk("d1_docl", bus1.docl, exp_rd(bus0.addr_c, 1'b0, 1'b1));
  endtask

  task automatic drive(input bit r, input bit c, input int aa, input int ab, input int ac,
                       input int h, input int l, input bit wh, input bit wl, input bit x,
                       input bit do_chk);
    @(negedge clk);
    reset_n     = r;
    bus0.cen    = c;
    bus0.addr_a = AW'(aa);
    bus0.addr_b = AW'(ab);
    bus0.addr_c = AW'(ac);
    bus0.dih    = DW'(h);
    bus0.dil    = DW'(l);
    bus0.weh    = wh;
    bus0.wel    = wl;
    bus0.exx    = x;
    #1;
    if (do_chk) check_all();
  endtask

  task automatic tick();
    int pb;
    int a;
    @(posedge clk);
    if (!reset_n) begin
      clr_left = NREG;
      mbank    = 0;
    end else if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) begin
        for (int b = 0; b < 2; b++)
          for (int i = 0; i < NREG; i++) begin
            mh[b][i] = 0;
            ml[b][i] = 0;
          end
      end
    end else if (bus0.cen) begin
      a  = int'(bus0.addr_a);
      pb = pbank(a);
      if (bus0.weh) mh[pb][a] = int'(bus0.dih);
      if (bus0.wel) ml[pb][a] = int'(bus0.dil);
      if (bus0.exx) mbank = 1 - mbank;
    end
    #1;
  endtask

  task automatic rd(input int a, input bit c);
    drive(1'b1, c, a, a, a, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wr(input int a, input int h, input int l, input bit wh, input bit wl,
                    input bit x);
    drive(1'b1, 1'b1, a, a, a, h, l, wh, wl, x, 1'b1);
    tick();
  endtask

  // Clear with writes attempted throughout; returns edges until busy drops.
  task automatic count_clear(output int n);
    n = 0;
    while (bus0.busy === 1'b1 && n < 20) begin
      drive(1'b1, 1'b1, n % NREG, 0, 1, 8'hFF, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    mbank    = 0;
    clr_left = NREG;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NREG; i++) begin
        mh[b][i] = 0;
        ml[b][i] = 0;
      end

    drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 3, 4, 5, 8'h12, 8'h34, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
    end
    chk("rst_busy", bus0.busy, 1);
    chk("rst_bank", bus0.bank, 0);
    chk("rst_doah", bus0.doah, 0);

    count_clear(n);
    chk("clr_latency", n, NREG);
    for (int a = 0; a < NREG; a++) begin
      rd(a, 1'b0);
      chk("clr_row_h", bus0.dobh, 0);
      chk("clr_row_l", bus0.docl, 0);
    end

    wr(3, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("lane_h", bus0.doah, 8'hA5);
    chk("lane_l_keep", bus0.doal, 8'h00);
    wr(3, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0);
    rd(3, 1'b0);
    chk("lane_b_h", bus0.dobh, 8'hA5);
    chk("lane_c_l", bus0.docl, 8'h5A);

    wr(4, 8'h66, 8'h67, 1'b1, 1'b1, 1'b0);
    wr(0, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0);
    wr(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    wr(0, 8'h33, 8'h44, 1'b1, 1'b1, 1'b0);
    rd(0, 1'b0);
    chk("exx_alt_h", bus0.doah, 8'h33);
    chk("exx_alt_l", bus0.doal, 8'h44);
    rd(4, 1'b0);
    chk("exx_row4_b1", bus0.dobh, 8'h66);
    wr(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    rd(0, 1'b0);
    chk("exx_main_h", bus0.doah, 8'h11);
    chk("exx_main_l", bus0.doal, 8'h22);
    rd(4, 1'b0);
    chk("exx_row4_b0", bus0.docl, 8'h67);

    wr(1, 8'h77, 8'h00, 1'b1, 1'b0, 1'b1);
    rd(1, 1'b0);
    chk("exx_wr_hidden", bus0.doah, 8'h00);
    chk("exx_wr_bank", bus0.bank, 1);
    wr(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    rd(1, 1'b0);
    chk("exx_wr_visible", bus0.doah, 8'h77);

    drive(1'b1, 1'b1, 2, 2, 6, 8'h9C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("byp_same_cycle", bus1.dobh, 8'h9C);
    chk("nobyp_old", bus0.dobh, 8'h00);
    tick();
    rd(2, 1'b0);
    chk("nobyp_next", bus0.dobh, 8'h9C);

    drive(1'b1, 1'b0, 5, 5, 5, 8'hEE, 8'hDD, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    rd(5, 1'b1);
    chk("cen_gate_h", bus0.doah, 8'h00);
    chk("cen_gate_bank", bus0.bank, 0);

    drive(1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, i, 0, 1, 8'hC3, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    count_clear(n);
    chk("midclr_latency", n, NREG);
    for (int a = 0; a < NREG; a++) begin
      rd(a, 1'b0);
      chk("midclr_row_h", bus0.doah, 0);
      chk("midclr_row_l", bus0.dobl, 0);
    end

    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 4) != 0),
            $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
            $urandom_range(0, NREG - 1), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 9) == 0), 1'b1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
